dds_sweep_ctrl: RTL

Sequencer that drives the phase-increment, duty (occupation) and waveform inputs of the DDS core, producing linear frequency sweeps. It holds a small config register file written over a single-cycle write strobe and steps the DDS frequency on the DDS period-sync pulse. Output changes happen only at waveform period boundaries, so they are glitch-free. Sits between the control/command logic and the DDS core, with its outputs wired directly to the DDS `inc_phi`, `occupation` and `waveform` inputs.

---
 rtl/dds_sweep_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dds_sweep_ctrl
// Description : Linear frequency-sweep sequencer for the DDS core. It drives
//               inc_phi, occupation and waveform and changes them only on
//               DDS period-sync edges.
//               Optional feature macro: DDS_SWEEP_UPDOWN_EN (up/down bounce).
// Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_wr,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        start,
    input  logic        stop,
    input  logic        sync,
    output logic [31:0] inc_phi,
    output logic [3:0]  occupation,
    output logic [3:0]  waveform,
    output logic        busy,
    output logic        done,
    output logic [15:0] step_cnt
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ARM   = 2'd1;
    localparam logic [1:0] c_S_DWELL = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

`ifdef DDS_SWEEP_UPDOWN_EN
    localparam int c_MODE_W = 10;
`else
    localparam int c_MODE_W = 9;
`endif

    logic [31:0]         r_cfg_start, r_cfg_stop, r_cfg_step;
    logic [15:0]         r_cfg_dwell;
    logic [c_MODE_W-1:0] r_cfg_mode;

    logic [31:0]         r_sh_start, r_sh_stop, r_sh_step;
    logic [15:0]         r_sh_dwell;
    logic [c_MODE_W-1:0] r_sh_mode;

    logic [1:0]          r_state;
    logic                r_sync_d;
    logic [15:0]         r_dwell_cnt;
    logic [31:0]         r_inc_phi;
    logic [3:0]          r_occupation, r_waveform;
    logic                r_busy, r_done;
    logic [15:0]         r_step_cnt;

    logic                w_sync_ev;
    logic                w_loop;
    logic [32:0]         w_up_sum;
    logic                w_up_fin;
    logic [31:0]         w_up_val;
    logic [31:0]         w_next_inc;
    logic                w_finish;

    assign w_sync_ev = sync & ~r_sync_d;
    assign w_loop    = r_sh_mode[8];

    // Config register file; always accepted, even while a sweep runs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_start <= 32'd0;
            r_cfg_stop  <= 32'd0;
            r_cfg_step  <= 32'd0;
            r_cfg_dwell <= 16'd1;
            r_cfg_mode  <= '0;
        end else if (cfg_wr) begin
            case (cfg_addr)
                3'd0:    r_cfg_start <= cfg_wdata;
                3'd1:    r_cfg_stop  <= cfg_wdata;
                3'd2:    r_cfg_step  <= cfg_wdata;
                3'd3:    r_cfg_dwell <= cfg_wdata[15:0];
                3'd4:    r_cfg_mode  <= cfg_wdata[c_MODE_W-1:0];
                default: ;
            endcase
        end
    end

    // Carry out of the 33-bit sum means the step overshot and must clamp.
    assign w_up_sum = {1'b0, r_inc_phi} + {1'b0, r_sh_step};
    assign w_up_fin = (r_inc_phi >= r_sh_stop);
    assign w_up_val = (w_up_sum[32] || (w_up_sum[31:0] >= r_sh_stop)) ? r_sh_stop : w_up_sum[31:0];

`ifdef DDS_SWEEP_UPDOWN_EN
    logic        r_dir_down;
    logic        w_updown;
    logic [32:0] w_dn_dif;
    logic        w_dn_fin;
    logic [31:0] w_dn_val;
    logic        w_next_dir;

    assign w_updown = r_sh_mode[9];
    assign w_dn_dif = {1'b0, r_inc_phi} - {1'b0, r_sh_step};
    assign w_dn_fin = (r_inc_phi <= r_sh_start);
    assign w_dn_val = (w_dn_dif[32] || (w_dn_dif[31:0] <= r_sh_start)) ? r_sh_start : w_dn_dif[31:0];

    always_comb begin
        w_next_inc = r_inc_phi;
        w_finish   = 1'b0;
        w_next_dir = r_dir_down;
        if (!r_dir_down) begin
            if (!w_up_fin) begin
                w_next_inc = w_up_val;
            end else if (w_updown) begin
                w_next_dir = 1'b1;
                if (!w_dn_fin)
                    w_next_inc = w_dn_val;
                else if (w_loop)
                    w_next_dir = 1'b0;
                else
                    w_finish = 1'b1;
            end else if (w_loop) begin
                w_next_inc = r_sh_start;
            end else begin
                w_finish = 1'b1;
            end
        end else begin
            if (!w_dn_fin) begin
                w_next_inc = w_dn_val;
            end else if (w_loop) begin
                w_next_dir = 1'b0;
                if (!w_up_fin)
                    w_next_inc = w_up_val;
            end else begin
                w_finish = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_dir_down <= 1'b0;
        else if (r_state == c_S_IDLE)
            r_dir_down <= 1'b0;
        else if (r_state == c_S_DWELL && !stop && w_sync_ev && r_dwell_cnt <= 16'd1)
            r_dir_down <= w_next_dir;
    end
`else
    always_comb begin
        w_next_inc = r_inc_phi;
        w_finish   = 1'b0;
        if (!w_up_fin)
            w_next_inc = w_up_val;
        else if (w_loop)
            w_next_inc = r_sh_start;
        else
            w_finish = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_S_IDLE;
            r_sync_d     <= 1'b0;
            r_dwell_cnt  <= 16'd0;
            r_inc_phi    <= 32'd0;
            r_occupation <= 4'd0;
            r_waveform   <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_step_cnt   <= 16'd0;
            r_sh_start   <= 32'd0;
            r_sh_stop    <= 32'd0;
            r_sh_step    <= 32'd0;
            r_sh_dwell   <= 16'd1;
            r_sh_mode    <= '0;
        end else begin
            r_sync_d <= sync;
            r_done   <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start && !stop) begin
                        r_state    <= c_S_ARM;
                        r_busy     <= 1'b1;
                        r_step_cnt <= 16'd0;
                        r_sh_start <= r_cfg_start;
                        r_sh_stop  <= r_cfg_stop;
                        r_sh_step  <= r_cfg_step;
                        r_sh_dwell <= (r_cfg_dwell == 16'd0) ? 16'd1 : r_cfg_dwell;
                        r_sh_mode  <= r_cfg_mode;
                    end
                end
                c_S_ARM: begin
                    if (stop) begin
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_sync_ev) begin
                        r_inc_phi    <= r_sh_start;
                        r_occupation <= r_sh_mode[7:4];
                        r_waveform   <= r_sh_mode[3:0];
                        r_dwell_cnt  <= r_sh_dwell;
                        r_state      <= c_S_DWELL;
                    end
                end
                c_S_DWELL: begin
                    if (stop) begin
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_sync_ev) begin
                        if (r_dwell_cnt <= 16'd1) begin
                            r_dwell_cnt <= r_sh_dwell;
                            if (w_finish) begin
                                r_state <= c_S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                // A zero step leaves the value unchanged and is not counted.
                                r_inc_phi <= w_next_inc;
                                if (w_next_inc != r_inc_phi)
                                    r_step_cnt <= r_step_cnt + 16'd1;
                            end
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt - 16'd1;
                        end
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign inc_phi    = r_inc_phi;
    assign occupation = r_occupation;
    assign waveform   = r_waveform;
    assign busy       = r_busy;
    assign done       = r_done;
    assign step_cnt   = r_step_cnt;

endmodule
`default_nettype wire
